// File: rtl/key_entry_buffer_if.sv
// Key entry bus: key strobes in, digit display and operand valid/ready out.
// master = key source / operand consumer side, slave = key_entry_buffer.
interface key_entry_buffer_if #(
  parameter int unsigned MAX_DIGITS = 4,
  parameter int unsigned OUT_W      = 14
);
  logic                             key_valid;
  logic [3:0]                       key_code;
  logic                             key_enter;
  logic [4*MAX_DIGITS-1:0]          digits_bcd;
  logic [$clog2(MAX_DIGITS+1)-1:0]  digit_count;
  logic [3:0]                       op_code;
  logic [OUT_W-1:0]                 operand_out;
  logic                             operand_neg;
  logic                             operand_valid;
  logic                             operand_ready;
  logic                             busy;

  modport master (
    output key_valid, key_code, key_enter, operand_ready,
    input  digits_bcd, digit_count, op_code, operand_out, operand_neg, operand_valid, busy
  );

  modport slave (
    input  key_valid, key_code, key_enter, operand_ready,
    output digits_bcd, digit_count, op_code, operand_out, operand_neg, operand_valid, busy
  );
endinterface

// File: rtl/key_entry_buffer.sv
// Key entry buffer: collects decoded digit keys into a right-aligned BCD store, tracks the last
// operator, and on enter converts the digits to a binary operand offered on valid/ready.
// Optional macro KEY_ENTRY_NEG_SIGN_EN: a leading '-' key sets a sign flag instead of an operator.
module key_entry_buffer #(
  parameter int unsigned MAX_DIGITS = 4,
  parameter int unsigned OUT_W      = 14
) (
  input logic              clk,
  input logic              rst_n,
  key_entry_buffer_if.slave bus
);
  localparam int unsigned CNT_W   = $clog2(MAX_DIGITS + 1);
  localparam int unsigned STORE_W = 4 * MAX_DIGITS;

  typedef enum logic [1:0] {StEntry, StConvert, StPresent} state_e;

  state_e             state_q;
  logic [STORE_W-1:0] store_q;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   conv_cnt_q;
  logic [OUT_W-1:0]   acc_q;
  logic [OUT_W-1:0]   operand_q;
  logic [3:0]         op_q;
  logic               neg_q;
  logic               valid_q;
  logic               busy_q;

  logic [3:0]         slot;
  logic [OUT_W+3:0]   acc_x10;
  logic [OUT_W-1:0]   acc_next;

  // Pick the slot for this convert step: step 0 reads the top slot, last step reads slot 0.
  always_comb begin
    slot = 4'h0;
    for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
      if (CNT_W'(MAX_DIGITS - 1 - i) == conv_cnt_q) slot = store_q[4*i +: 4];
    end
  end

  // acc*10 + digit, shift-and-add in a widened word, then truncated.
  always_comb begin
    acc_x10  = ({4'b0, acc_q} << 3) + ({4'b0, acc_q} << 1);
    acc_next = acc_x10[OUT_W-1:0] + OUT_W'(slot);
  end

  // Display view: held digits shown, empty slots read F.
  always_comb begin
    bus.digits_bcd = '1;
    for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
      if (CNT_W'(i) < count_q) bus.digits_bcd[4*i +: 4] = store_q[4*i +: 4];
    end
  end

  assign bus.digit_count   = count_q;
  assign bus.op_code       = op_q;
  assign bus.operand_out   = operand_q;
  assign bus.operand_neg   = neg_q;
  assign bus.operand_valid = valid_q;
  assign bus.busy          = busy_q;

  // Main FSM: key decode in entry, fixed-length conversion, then hold operand until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StEntry;
      store_q    <= '0;
      count_q    <= '0;
      conv_cnt_q <= '0;
      acc_q      <= '0;
      operand_q  <= '0;
      op_q       <= 4'hF;
      neg_q      <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        StEntry: begin
          if (bus.key_valid) begin
            if (bus.key_enter) begin
              state_q    <= StConvert;
              busy_q     <= 1'b1;
              acc_q      <= '0;
              conv_cnt_q <= '0;
            end else if (bus.key_code <= 4'h9) begin
              // A full buffer drops further digits.
              if (count_q != CNT_W'(MAX_DIGITS)) begin
                store_q <= {store_q[STORE_W-5:0], bus.key_code};
                count_q <= count_q + CNT_W'(1);
              end
            end else if (bus.key_code == 4'hE) begin
              if (count_q != '0) begin
                store_q <= {4'h0, store_q[STORE_W-1:4]};
                count_q <= count_q - CNT_W'(1);
              end
`ifdef KEY_ENTRY_NEG_SIGN_EN
              else if (neg_q) begin
                neg_q <= 1'b0;
              end
`endif
            end else if (bus.key_code == 4'hA) begin
`ifdef KEY_ENTRY_NEG_SIGN_EN
              if (count_q == '0 && !neg_q) neg_q <= 1'b1;
              else                         op_q  <= 4'hA;
`else
              op_q <= 4'hA;
`endif
            end else if (bus.key_code != 4'hF) begin
              op_q <= bus.key_code;
            end
          end
        end
        StConvert: begin
          if (conv_cnt_q != CNT_W'(MAX_DIGITS)) begin
            acc_q      <= acc_next;
            conv_cnt_q <= conv_cnt_q + CNT_W'(1);
          end else begin
            operand_q <= acc_q;
            valid_q   <= 1'b1;
            state_q   <= StPresent;
          end
        end
        StPresent: begin
          if (bus.operand_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= StEntry;
            store_q <= '0;
            count_q <= '0;
            op_q    <= 4'hF;
            neg_q   <= 1'b0;
          end
        end
        default: state_q <= StEntry;
      endcase
    end
  end
endmodule

// File: tb/tb_key_entry_buffer.sv
// Bench for key_entry_buffer: expected operands queued at enter, compared on handshake.
module tb_key_entry_buffer;
  localparam int unsigned MAX_DIGITS = 4;
  localparam int unsigned OUT_W      = 14;

  typedef struct {
    logic [OUT_W-1:0] operand;
    logic [3:0]       op;
    logic             neg;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t sb[$];

  key_entry_buffer_if #(.MAX_DIGITS(MAX_DIGITS), .OUT_W(OUT_W)) bus ();

  key_entry_buffer #(.MAX_DIGITS(MAX_DIGITS), .OUT_W(OUT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] code);
    bus.key_valid = 1'b1;
    bus.key_code  = code;
    tick();
    bus.key_valid = 1'b0;
  endtask

  // Enter, then walk the fixed latency: valid low for MAX_DIGITS cycles, high on the next.
  task automatic enter_and_wait(input logic [OUT_W-1:0] operand, input logic [3:0] op,
                                input logic neg);
    exp_t e;
    e.operand = operand;
    e.op      = op;
    e.neg     = neg;
    sb.push_back(e);
    bus.key_valid = 1'b1;
    bus.key_enter = 1'b1;
    tick();
    bus.key_valid = 1'b0;
    bus.key_enter = 1'b0;
    check("busy_after_enter", bus.busy, 1);
    for (int n = 1; n <= MAX_DIGITS + 1; n++) begin
      tick();
      check($sformatf("latency_c%0d", n), bus.operand_valid, (n == MAX_DIGITS + 1) ? 1 : 0);
    end
  endtask

  // Accept with ready, comparing against the oldest expected operand.
  task automatic accept();
    exp_t e;
    bus.operand_ready = 1'b1;
    check("valid_at_accept", bus.operand_valid, 1);
    if (sb.size() == 0) begin
      check("scoreboard_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      check("operand_out", bus.operand_out, e.operand);
      check("op_code", bus.op_code, e.op);
      check("operand_neg", bus.operand_neg, e.neg);
    end
    tick();
    bus.operand_ready = 1'b0;
    check("valid_after_accept", bus.operand_valid, 0);
    check("busy_after_accept", bus.busy, 0);
    check("digits_after_accept", bus.digits_bcd, 16'hFFFF);
    check("count_after_accept", bus.digit_count, 0);
    check("op_after_accept", bus.op_code, 4'hF);
    check("neg_after_accept", bus.operand_neg, 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_digits"}, bus.digits_bcd, 16'hFFFF);
    check({tag, "_count"}, bus.digit_count, 0);
    check({tag, "_op"}, bus.op_code, 4'hF);
    check({tag, "_operand"}, bus.operand_out, 0);
    check({tag, "_neg"}, bus.operand_neg, 0);
    check({tag, "_valid"}, bus.operand_valid, 0);
    check({tag, "_busy"}, bus.busy, 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.key_valid     = 1'b0;
    bus.key_code      = 4'hF;
    bus.key_enter     = 1'b0;
    bus.operand_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    check_reset_values("reset");
    rst_n = 1'b1;
    tick();

    // Basic entry 1,2,3.
    press(4'h1);
    press(4'h2);
    press(4'h3);
    check("digits_123", bus.digits_bcd, 16'hF123);
    check("count_123", bus.digit_count, 3);
    enter_and_wait(14'd123, 4'hF, 1'b0);
    accept();

    // Overflow: fifth digit dropped.
    press(4'h9);
    press(4'h9);
    press(4'h9);
    press(4'h9);
    press(4'h5);
    check("digits_9999", bus.digits_bcd, 16'h9999);
    check("count_full", bus.digit_count, 4);
    enter_and_wait(14'h270F, 4'hF, 1'b0);
    accept();

    // Backspace sequence.
    begin
      logic [3:0]  keys [6];
      logic [15:0] disp [6];
      keys = '{4'h4, 4'h7, 4'hE, 4'hE, 4'hE, 4'h8};
      disp = '{16'hFFF4, 16'hFF47, 16'hFFF4, 16'hFFFF, 16'hFFFF, 16'hFFF8};
      for (int i = 0; i < 6; i++) begin
        press(keys[i]);
        check($sformatf("bksp_step%0d", i), bus.digits_bcd, disp[i]);
      end
    end
    enter_and_wait(14'd8, 4'hF, 1'b0);
    accept();

    // Operator plus back-pressure; keys while busy are dropped.
    press(4'h5);
    press(4'hB);
    press(4'h6);
    check("op_latched", bus.op_code, 4'hB);
    enter_and_wait(14'd56, 4'hB, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) press(4'h1);
      else if (i == 5) press(4'h2);
      else tick();
      check($sformatf("hold_valid%0d", i), bus.operand_valid, 1);
      check($sformatf("hold_operand%0d", i), bus.operand_out, 56);
      check($sformatf("hold_op%0d", i), bus.op_code, 4'hB);
      check($sformatf("hold_busy%0d", i), bus.busy, 1);
    end
    check("dropped_keys_digits", bus.digits_bcd, 16'hFF56);
    accept();
    tick();
    check("single_accept", bus.operand_valid, 0);
    check("operand_holds", bus.operand_out, 56);

    // Reset mid-convert aborts with no valid.
    press(4'h7);
    bus.key_valid = 1'b1;
    bus.key_enter = 1'b1;
    tick();
    bus.key_valid = 1'b0;
    bus.key_enter = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check_reset_values("abort");
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("no_valid_after_abort%0d", i), bus.operand_valid, 0);
    end

    // Enter with no digits.
    enter_and_wait(14'd0, 4'hF, 1'b0);
    accept();

`ifdef KEY_ENTRY_NEG_SIGN_EN
    press(4'hA);
    check("neg_set", bus.operand_neg, 1);
    press(4'h4);
    press(4'h2);
    enter_and_wait(14'd42, 4'hF, 1'b1);
    accept();
    press(4'h3);
    press(4'hA);
    enter_and_wait(14'd3, 4'hA, 1'b0);
    accept();
    press(4'hA);
    press(4'hE);
    check("neg_cleared_by_bksp", bus.operand_neg, 0);
    check("op_after_neg_bksp", bus.op_code, 4'hF);
`else
    press(4'hA);
    check("minus_is_operator", bus.op_code, 4'hA);
    check("neg_tied_low", bus.operand_neg, 0);
    press(4'h4);
    press(4'h2);
    enter_and_wait(14'd42, 4'hA, 1'b0);
    accept();
`endif

    check("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
